// File: rtl/bist_response_analyzer.sv
// MISR response compactor and BIST session FSM; start-to-done is NUM_PATTERNS+1 edges when resp_valid stays high.
// No backpressure: a RUN session simply stalls while resp_valid is low, with no timeout.
module bist_response_analyzer #(
    parameter int                 WIDTH        = 4,
    parameter int                 RESP_W       = 2,
    parameter logic [WIDTH-1:0]   POLY         = 4'b1100,
    parameter logic [WIDTH-1:0]   SEED         = 4'b0000,
    parameter int                 NUM_PATTERNS = 7,
    parameter logic [WIDTH-1:0]   GOLDEN       = 4'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    output logic              pat_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [WIDTH-1:0]  signature,
    output logic [7:0]        pattern_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_PATTERNS - 1);

    state_t           state;
    logic [WIDTH-1:0] misr;
    logic             fb;
    logic [WIDTH-1:0] misr_next;

    assign fb        = ^(misr & POLY);
    assign misr_next = {misr[WIDTH-2:0], fb} ^ WIDTH'(resp);
    assign signature = misr;

    // Outputs are set on the transition edge so they read as registered state decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            misr        <= '0;
            pattern_cnt <= 8'd0;
            pat_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        misr        <= SEED;
                        pattern_cnt <= 8'd0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        done        <= 1'b0;
                        pat_en      <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        misr        <= misr_next;
                        pattern_cnt <= pattern_cnt + 8'd1;
                        if (pattern_cnt == LAST_IDX) begin
                            state  <= COMPARE;
                            pat_en <= 1'b0;
                        end
                    end
                end
                COMPARE: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (misr == GOLDEN);
                    fail  <= (misr != GOLDEN);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench: one short-session instance (3 patterns, golden 7) and one default-parameter instance.
module tb_bist_response_analyzer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: NUM_PATTERNS=3, GOLDEN=7
    logic       a_rst, a_start, a_resp_valid;
    logic [1:0] a_resp;
    logic       a_pat_en, a_busy, a_done, a_pass, a_fail;
    logic [3:0] a_sig;
    logic [7:0] a_cnt;

    // Instance B: default parameters
    logic       b_rst, b_start, b_resp_valid;
    logic [1:0] b_resp;
    logic       b_pat_en, b_busy, b_done, b_pass, b_fail;
    logic [3:0] b_sig;
    logic [7:0] b_cnt;

    bist_response_analyzer #(
        .WIDTH(4), .RESP_W(2), .POLY(4'b1100), .SEED(4'b0000),
        .NUM_PATTERNS(3), .GOLDEN(4'h7)
    ) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .resp_valid(a_resp_valid), .resp(a_resp),
        .pat_en(a_pat_en), .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail),
        .signature(a_sig), .pattern_cnt(a_cnt)
    );

    bist_response_analyzer dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .resp_valid(b_resp_valid), .resp(b_resp),
        .pat_en(b_pat_en), .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail),
        .signature(b_sig), .pattern_cnt(b_cnt)
    );

    logic [3:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {pat_en, busy, done, pass, fail}
    task automatic chk_a_flags(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, a_pat_en, a_busy, a_done, a_pass, a_fail}, {27'd0, exp});
    endtask

    task automatic chk_b_flags(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, b_pat_en, b_busy, b_done, b_pass, b_fail}, {27'd0, exp});
    endtask

    // Drive one cycle on A; valid samples push their expected signature and are checked after the edge.
    task automatic a_sample(input string tag, input logic v, input logic [1:0] r,
                            input logic [3:0] exp_sig, input logic [7:0] exp_cnt);
        logic [3:0] e;
        a_resp_valid = v;
        a_resp       = r;
        if (v) sb_q.push_back(exp_sig);
        step();
        if (v) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk({tag, "_sig"}, {28'd0, a_sig}, {28'd0, e});
            end
        end else begin
            chk({tag, "_hold_sig"}, {28'd0, a_sig}, {28'd0, exp_sig});
        end
        chk({tag, "_cnt"}, {24'd0, a_cnt}, {24'd0, exp_cnt});
        a_resp_valid = 1'b0;
    endtask

    task automatic a_start_session(input string tag);
        a_start      = 1'b1;
        a_resp_valid = 1'b1;   // must be ignored on the start edge
        a_resp       = 2'b11;
        step();
        a_start      = 1'b0;
        a_resp_valid = 1'b0;
        chk_a_flags({tag, "_start_flags"}, 5'b11000);
        chk({tag, "_start_sig"}, {28'd0, a_sig}, 32'd0);
        chk({tag, "_start_cnt"}, {24'd0, a_cnt}, 32'd0);
    endtask

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_resp_valid = 1'b0; a_resp = 2'b00;
        b_rst = 1'b1; b_start = 1'b0; b_resp_valid = 1'b0; b_resp = 2'b00;
        step();
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        chk_a_flags("reset_a_flags", 5'b00000);
        chk("reset_a_sig", {28'd0, a_sig}, 32'd0);
        chk("reset_a_cnt", {24'd0, a_cnt}, 32'd0);
        chk_b_flags("reset_b_flags", 5'b00000);
        chk("reset_b_sig", {28'd0, b_sig}, 32'd0);

        // Passing session: 01,01,01 -> 1,3,7
        a_start_session("pass");
        a_sample("pass_s1", 1'b1, 2'b01, 4'h1, 8'd1);
        chk_a_flags("pass_s1_flags", 5'b11000);
        a_sample("pass_s2", 1'b1, 2'b01, 4'h3, 8'd2);
        a_sample("pass_s3", 1'b1, 2'b01, 4'h7, 8'd3);
        chk_a_flags("pass_compare_flags", 5'b01000);
        step();
        chk_a_flags("pass_done_flags", 5'b00110);
        chk("pass_done_cnt", {24'd0, a_cnt}, 32'd3);
        a_resp_valid = 1'b1;
        a_resp       = 2'b10;
        step();
        a_resp_valid = 1'b0;
        chk_a_flags("pass_hold_flags", 5'b00110);
        chk("pass_hold_sig", {28'd0, a_sig}, 32'h7);
        chk("pass_hold_cnt", {24'd0, a_cnt}, 32'd3);

        // Restart from DONE, second response zero: 1,2,5 -> fail
        a_start_session("fail");
        a_sample("fail_s1", 1'b1, 2'b01, 4'h1, 8'd1);
        a_sample("fail_s2", 1'b1, 2'b00, 4'h2, 8'd2);
        a_sample("fail_s3", 1'b1, 2'b01, 4'h5, 8'd3);
        step();
        chk_a_flags("fail_done_flags", 5'b00101);
        chk("fail_done_sig", {28'd0, a_sig}, 32'h5);

        // Two idle cycles between samples: done lands two edges later
        a_start_session("gap");
        a_sample("gap_s1", 1'b1, 2'b01, 4'h1, 8'd1);
        a_sample("gap_h1", 1'b0, 2'b11, 4'h1, 8'd1);
        a_sample("gap_h2", 1'b0, 2'b10, 4'h1, 8'd1);
        a_sample("gap_s2", 1'b1, 2'b01, 4'h3, 8'd2);
        a_sample("gap_s3", 1'b1, 2'b01, 4'h7, 8'd3);
        chk_a_flags("gap_not_done_yet", 5'b01000);
        step();
        chk_a_flags("gap_done_flags", 5'b00110);

        // start pulsed mid-RUN is ignored
        a_start_session("midstart");
        a_sample("midstart_s1", 1'b1, 2'b01, 4'h1, 8'd1);
        a_start = 1'b1;
        a_sample("midstart_s2", 1'b1, 2'b01, 4'h3, 8'd2);
        a_start = 1'b0;
        a_sample("midstart_s3", 1'b1, 2'b01, 4'h7, 8'd3);
        a_start = 1'b1;   // in COMPARE: also ignored
        step();
        a_start = 1'b0;
        chk_a_flags("midstart_done_flags", 5'b00110);
        chk("midstart_done_cnt", {24'd0, a_cnt}, 32'd3);

        // Reset mid-RUN with start held: stays IDLE
        a_start_session("rst");
        a_sample("rst_s1", 1'b1, 2'b01, 4'h1, 8'd1);
        a_rst   = 1'b1;
        a_start = 1'b1;
        a_resp_valid = 1'b1;
        step();
        chk_a_flags("rst_c1_flags", 5'b00000);
        chk("rst_c1_sig", {28'd0, a_sig}, 32'd0);
        step();
        chk_a_flags("rst_c2_flags", 5'b00000);
        chk("rst_c2_cnt", {24'd0, a_cnt}, 32'd0);
        a_rst = 1'b0;
        a_start = 1'b0;
        step();
        a_resp_valid = 1'b0;
        chk_a_flags("rst_after_flags", 5'b00000);
        chk("rst_after_sig", {28'd0, a_sig}, 32'd0);
        chk("rst_after_cnt", {24'd0, a_cnt}, 32'd0);

        // Default instance: seven zero responses, done after start+8 edges
        b_start      = 1'b1;
        b_resp_valid = 1'b1;
        b_resp       = 2'b00;
        step();
        b_start = 1'b0;
        chk_b_flags("dflt_start_flags", 5'b11000);
        for (int i = 1; i <= 7; i++) begin
            sb_q.push_back(4'h0);
            step();
            if (sb_q.size() != 0) chk($sformatf("dflt_s%0d_sig", i), {28'd0, b_sig}, {28'd0, sb_q.pop_front()});
            chk($sformatf("dflt_s%0d_cnt", i), {24'd0, b_cnt}, i);
            chk($sformatf("dflt_s%0d_done", i), {31'd0, b_done}, 32'd0);
        end
        step();
        b_resp_valid = 1'b0;
        chk_b_flags("dflt_done_flags", 5'b00110);
        chk("dflt_done_cnt", {24'd0, b_cnt}, 32'd7);

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
